// File: rtl/cpu_mem_arb_pkg.sv
// rtl/cpu_mem_arb_pkg.sv - shared types and constants for the CPU / I-cache memory arbiter
package cpu_mem_arb_pkg;

  localparam int ARB_ADDR_BITS = 15;
  localparam int ARB_DATA_BITS = 16;
  localparam int READ_LATENCY  = 2;

  typedef enum logic {
    SRC_IC = 1'b0,
    SRC_D  = 1'b1
  } src_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IC_RUN = 2'd1,
    D_RUN  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                     valid;
    src_e                     src;
    logic [ARB_ADDR_BITS-1:0] addr;
  } tag_t;

  localparam tag_t TAG_NONE = '{valid: 1'b0, src: SRC_IC, addr: '0};

endpackage

// File: rtl/cpu_mem_arb_tag_pipe.sv
// rtl/cpu_mem_arb_tag_pipe.sv - read-return tag shift register, READ_LATENCY deep, cleared synchronously
module cpu_mem_arb_tag_pipe
  import cpu_mem_arb_pkg::*;
(
  input  logic CLK,
  input  logic RSTb,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage [READ_LATENCY];

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      for (int i = 0; i < READ_LATENCY; i++) stage[i] <= TAG_NONE;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < READ_LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[READ_LATENCY-1];

endmodule

// File: rtl/cpu_memory_arbiter.sv
// rtl/cpu_memory_arbiter.sv - shares one memory port between I-cache fills and CPU load/store
// Optional fill starvation guard: CPU_MEM_ARB_STARVE_GUARD_EN
module cpu_memory_arbiter
  import cpu_mem_arb_pkg::*;
#(
  parameter int ADDR_BITS = ARB_ADDR_BITS,
  parameter int DATA_BITS = ARB_DATA_BITS
`ifdef CPU_MEM_ARB_STARVE_GUARD_EN
  ,
  parameter int STARVE_LIMIT = 4
`endif
) (
  input  logic                 CLK,
  input  logic                 RSTb,
  input  logic [ADDR_BITS-1:0] ic_address,
  input  logic                 ic_rd_req,
  output logic                 ic_will_queue,
  output logic                 ic_success,
  output logic [ADDR_BITS-1:0] ic_req_address,
  output logic [DATA_BITS-1:0] ic_data,
  input  logic                 d_req,
  input  logic                 d_wr,
  input  logic [ADDR_BITS-1:0] d_address,
  input  logic [DATA_BITS-1:0] d_wdata,
  input  logic [1:0]           d_wmask,
  output logic                 d_grant,
  output logic                 d_rvalid,
  output logic [DATA_BITS-1:0] d_rdata,
  output logic [ADDR_BITS-1:0] mem_address,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [DATA_BITS-1:0] mem_wdata,
  output logic [1:0]           mem_wmask,
  input  logic [DATA_BITS-1:0] mem_rdata
);

  arb_state_e state;
  logic       issue_wr;
  logic       force_ic;
  tag_t       tag_in;
  tag_t       tag_out;

`ifdef CPU_MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  // Once the data side has won STARVE_LIMIT times in a row over a waiting fill, the fill goes next.
  assign force_ic = ic_rd_req && (starve_cnt == CNT_W'(STARVE_LIMIT));

  always_ff @(posedge CLK) begin
    if (!RSTb || !ic_rd_req || ic_will_queue) begin
      starve_cnt <= '0;
    end else if (d_grant && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign force_ic = 1'b0;
`endif

  assign d_grant       = d_req & ~force_ic;
  assign ic_will_queue = ic_rd_req & ~d_grant;

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state       <= IDLE;
      issue_wr    <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      mem_wmask   <= '0;
    end else if (d_grant) begin
      state       <= D_RUN;
      issue_wr    <= d_wr;
      mem_address <= d_address;
      mem_wdata   <= d_wdata;
      mem_wmask   <= d_wr ? d_wmask : 2'b00;
    end else if (ic_will_queue) begin
      state       <= IC_RUN;
      issue_wr    <= 1'b0;
      mem_address <= ic_address;
      mem_wmask   <= 2'b00;
    end else begin
      state       <= IDLE;
      issue_wr    <= 1'b0;
    end
  end

  // The grant-history state doubles as the issue strobe: anything but IDLE is an access in flight.
  assign mem_rd = (state == IC_RUN) || ((state == D_RUN) && !issue_wr);
  assign mem_wr = (state == D_RUN) && issue_wr;

  always_comb begin
    tag_in = TAG_NONE;
    if (d_grant) begin
      tag_in.valid = ~d_wr;
      tag_in.src   = SRC_D;
      tag_in.addr  = d_address;
    end else if (ic_will_queue) begin
      tag_in.valid = 1'b1;
      tag_in.src   = SRC_IC;
      tag_in.addr  = ic_address;
    end
  end

  cpu_mem_arb_tag_pipe u_tag_pipe (
    .CLK     (CLK),
    .RSTb    (RSTb),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Gating with RSTb keeps a read that was in flight when reset hit from reporting during the reset cycle.
  assign ic_success     = RSTb && tag_out.valid && (tag_out.src == SRC_IC);
  assign d_rvalid       = RSTb && tag_out.valid && (tag_out.src == SRC_D);
  assign ic_req_address = tag_out.addr;
  assign ic_data        = mem_rdata;
  assign d_rdata        = mem_rdata;

endmodule

// File: tb/tb_cpu_memory_arbiter.sv
// tb/tb_cpu_memory_arbiter.sv - scoreboard bench for cpu_memory_arbiter with a word-level memory reference model
module tb_cpu_memory_arbiter;

`ifdef CPU_MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int STARVE = 4;

  logic        CLK = 1'b0;
  logic        RSTb = 1'b0;
  logic [14:0] ic_address = '0;
  logic        ic_rd_req = 1'b0;
  logic        ic_will_queue, ic_success;
  logic [14:0] ic_req_address;
  logic [15:0] ic_data;
  logic        d_req = 1'b0, d_wr = 1'b0;
  logic [14:0] d_address = '0;
  logic [15:0] d_wdata = '0;
  logic [1:0]  d_wmask = '0;
  logic        d_grant, d_rvalid;
  logic [15:0] d_rdata;
  logic [14:0] mem_address;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_wmask;
  logic [15:0] mem_rdata = '0;

  cpu_memory_arbiter dut (
    .CLK(CLK), .RSTb(RSTb),
    .ic_address(ic_address), .ic_rd_req(ic_rd_req), .ic_will_queue(ic_will_queue),
    .ic_success(ic_success), .ic_req_address(ic_req_address), .ic_data(ic_data),
    .d_req(d_req), .d_wr(d_wr), .d_address(d_address), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_grant(d_grant), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_address(mem_address), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  // Synchronous memory attached to the mem_* port.
  logic [15:0] mem [0:32767];
  always @(posedge CLK) begin
    if (mem_wr) begin
      if (mem_wmask[1]) mem[mem_address][15:8] = mem_wdata[15:8];
      if (mem_wmask[0]) mem[mem_address][7:0]  = mem_wdata[7:0];
    end
    if (mem_rd) mem_rdata <= mem[mem_address];
  end

  // Reference: memory contents as seen in grant order, plus expected returns with due cycle.
  logic [15:0] ref_mem [0:32767];
  typedef struct {
    bit          is_d;
    logic [14:0] addr;
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t expq[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int m_cnt = 0;
  int ic_succ_cnt = 0;
  logic [15:0] last_ic_data = '0, last_d_data = '0;
  logic [14:0] last_ic_addr = '0;
  bit obs_icq;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a return is due and checks nothing else is returned.
  always @(negedge CLK) begin
    if (!RSTb) begin
      chk("rst_no_valid", {30'd0, ic_success, d_rvalid}, 32'd0);
    end else begin
      chk("mem_rd_wr_excl", {31'd0, mem_rd & mem_wr}, 32'd0);
      if (expq.size() > 0 && expq[0].due == cyc) begin
        exp_t e;
        e = expq.pop_front();
        if (e.is_d) begin
          chk("d_ret_valid", {30'd0, ic_success, d_rvalid}, 32'd1);
          chk("d_rdata", {16'd0, d_rdata}, {16'd0, e.data});
          last_d_data = d_rdata;
        end else begin
          chk("ic_ret_valid", {30'd0, ic_success, d_rvalid}, 32'd2);
          chk("ic_req_address", {17'd0, ic_req_address}, {17'd0, e.addr});
          chk("ic_data", {16'd0, ic_data}, {16'd0, e.data});
          last_ic_data = ic_data;
          last_ic_addr = ic_req_address;
        end
      end else begin
        chk("no_spurious_ret", {30'd0, ic_success, d_rvalid}, 32'd0);
      end
      if (ic_success) ic_succ_cnt++;
    end
  end

  // One request cycle: drive, predict the grant, check it, update the reference.
  task automatic step(input bit ir, input logic [14:0] ia, input bit dr, input bit dw,
                      input logic [14:0] da, input logic [15:0] wd, input logic [1:0] wm,
                      output bit ic_g, output bit d_g);
    bit force_ic;
    logic [15:0] old;
    ic_rd_req = ir; ic_address = ia;
    d_req = dr; d_wr = dw; d_address = da; d_wdata = wd; d_wmask = wm;
    force_ic = GUARD && ir && (m_cnt == STARVE);
    d_g  = dr && !force_ic;
    ic_g = ir && !d_g;
    @(negedge CLK);
    obs_icq = ic_will_queue;
    chk("grant {d_grant,ic_will_queue}", {30'd0, d_grant, ic_will_queue}, {30'd0, d_g, ic_g});
    if (d_g) begin
      if (dw) begin
        old = ref_mem[da];
        ref_mem[da] = {wm[1] ? wd[15:8] : old[15:8], wm[0] ? wd[7:0] : old[7:0]};
      end else begin
        expq.push_back('{is_d: 1'b1, addr: da, data: ref_mem[da], due: cyc + 2});
      end
    end else if (ic_g) begin
      expq.push_back('{is_d: 1'b0, addr: ia, data: ref_mem[ia], due: cyc + 2});
    end
    if (!ir || ic_g) m_cnt = 0;
    else if (d_g && m_cnt < STARVE) m_cnt++;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    bit a, b;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0, 2'b00, a, b);
  endtask

  task automatic drain();
    bit a, b;
    for (int i = 0; i < 8 && expq.size() > 0; i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0, 2'b00, a, b);
    idle(1);
    chk("drain_empty", expq.size(), 32'd0);
  endtask

  task automatic preload(input logic [14:0] a, input logic [15:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic do_reset(input int n);
    RSTb = 1'b0;
    ic_rd_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    expq.delete();
    m_cnt = 0;
    repeat (n) @(posedge CLK);
    #1;
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_address", {17'd0, mem_address}, 32'd0);
    chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    chk("rst_mem_wmask", {30'd0, mem_wmask}, 32'd0);
    chk("rst_ic_req_address", {17'd0, ic_req_address}, 32'd0);
    RSTb = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit icg, dg, ic_pend, d_pend, dw;
    logic [14:0] ia, da;
    logic [15:0] wd;
    logic [1:0]  wm;
    int base, first_ic;
    for (int i = 0; i < 32768; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    preload(15'h0010, 16'hBEEF);
    preload(15'h0020, 16'h5566);
    do_reset(3);

    // ic only
    step(1'b1, 15'h0010, 1'b0, 1'b0, '0, '0, 2'b00, icg, dg);
    chk("ic_only_will_queue", {31'd0, obs_icq}, 32'd1);
    drain();
    chk("ic_only_data", {16'd0, last_ic_data}, 32'h0000BEEF);
    chk("ic_only_addr", {17'd0, last_ic_addr}, 32'h00000010);

    // contention: data wins, fill goes next cycle
    step(1'b1, 15'h0011, 1'b1, 1'b0, 15'h0200, '0, 2'b00, icg, dg);
    step(1'b1, 15'h0011, 1'b0, 1'b0, '0, '0, 2'b00, icg, dg);
    chk("contention_ic_next", {31'd0, obs_icq}, 32'd1);
    drain();

    // write then fill at the same address
    step(1'b1, 15'h0011, 1'b1, 1'b1, 15'h0011, 16'h1234, 2'b11, icg, dg);
    step(1'b1, 15'h0011, 1'b0, 1'b0, '0, '0, 2'b00, icg, dg);
    drain();
    chk("write_then_fill", {16'd0, last_ic_data}, 32'h00001234);

    // byte-lane write
    step(1'b0, '0, 1'b1, 1'b1, 15'h0020, 16'hAB00, 2'b10, icg, dg);
    step(1'b0, '0, 1'b1, 1'b0, 15'h0020, '0, 2'b00, icg, dg);
    drain();
    chk("byte_write", {16'd0, last_d_data}, 32'h0000AB66);

    // streaming fills
    base = ic_succ_cnt;
    for (int i = 0; i < 16; i++) step(1'b1, 15'(i), 1'b0, 1'b0, '0, '0, 2'b00, icg, dg);
    drain();
    chk("stream_count", ic_succ_cnt - base, 32'd16);

    // reset with two reads in flight
    step(1'b1, 15'h0010, 1'b0, 1'b0, '0, '0, 2'b00, icg, dg);
    step(1'b0, '0, 1'b1, 1'b0, 15'h0020, '0, 2'b00, icg, dg);
    base = ic_succ_cnt;
    do_reset(1);
    idle(4);
    chk("reset_no_success", ic_succ_cnt - base, 32'd0);
    chk("reset_mem_rd", {31'd0, mem_rd}, 32'd0);

    // continuous data reads against a held fill
    ic_pend = 1'b1;
    first_ic = 0;
    for (int k = 1; k <= 8; k++) begin
      step(ic_pend, 15'h0030, 1'b1, 1'b0, 15'h0040, '0, 2'b00, icg, dg);
      if (obs_icq && first_ic == 0) first_ic = k;
      if (icg) ic_pend = 1'b0;
    end
    chk("starve_first_ic_grant", first_ic, GUARD ? 32'd5 : 32'd0);
    if (ic_pend) step(1'b1, 15'h0030, 1'b0, 1'b0, '0, '0, 2'b00, icg, dg);
    drain();

    // randomized traffic with held requests
    ic_pend = 1'b0; d_pend = 1'b0;
    ia = '0; da = '0; dw = 1'b0; wd = '0; wm = '0;
    for (int n = 0; n < 400; n++) begin
      if (!ic_pend && ($urandom % 3 == 0)) begin
        ic_pend = 1'b1;
        ia = 15'($urandom % 32);
      end
      if (!d_pend && ($urandom % 2 == 0)) begin
        d_pend = 1'b1;
        dw = 1'($urandom % 2);
        da = 15'($urandom % 32);
        wd = 16'($urandom);
        wm = 2'($urandom);
      end
      step(ic_pend, ia, d_pend, dw, da, wd, wm, icg, dg);
      if (icg) ic_pend = 1'b0;
      if (dg) d_pend = 1'b0;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
